// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole scheduler: states, level codes and
// the hole-index fold that maps a 3-bit random value onto the five holes.
package mole_pkg;

    localparam int NUM_HOLES = 5;

    localparam logic [1:0] LVL_EASY = 2'd0;
    localparam logic [1:0] LVL_MED  = 2'd1;
    localparam logic [1:0] LVL_HARD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Values 5..7 fold down onto holes 2..4, then a repeat of the previous
    // hole is bumped to the next one so a hole never lights twice in a row.
    function automatic logic [2:0] fold_idx(input logic [2:0] raw,
                                            input logic [2:0] last);
        logic [2:0] v;
        v = (raw >= 3'd5) ? (raw - 3'd3) : raw;
        if (v == last) begin
            v = (v == 3'd4) ? 3'd0 : (v + 3'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the
// random source for hole selection.
module mole_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/mole_scheduler.sv
// Round sequencer: picks a hole, shows the mole for a level-dependent time,
// reports hit or timeout, then holds the board dark for a fixed gap.
//
// state | meaning
// IDLE  | game stopped, board dark
// PICK  | one cycle: choose hole, load lifetime, count the round
// SHOW  | mole lit, waiting for hit or lifetime expiry
// GAP   | board dark between moles
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int                 TICK_W        = 32,
    parameter logic [TICK_W-1:0]  ON_TICKS_EASY = 300_000_000,
    parameter logic [TICK_W-1:0]  ON_TICKS_MED  = 200_000_000,
    parameter logic [TICK_W-1:0]  ON_TICKS_HARD = 100_000_000,
    parameter logic [TICK_W-1:0]  GAP_TICKS     = 50_000_000,
    parameter logic [15:0]        LFSR_SEED     = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [1:0]           i_level,
    input  logic [NUM_HOLES-1:0] i_hit_vec,
    output logic [NUM_HOLES-1:0] o_mole_led,
    output logic                 o_hit_pulse,
    output logic                 o_timeout_pulse,
    output logic [7:0]           o_round_count
);

    state_t                r_state;
    logic [TICK_W-1:0]     r_timer;
    logic [2:0]            r_last_idx;
    logic [NUM_HOLES-1:0]  r_mole_led;
    logic                  r_hit_pulse;
    logic                  r_timeout_pulse;
    logic [7:0]            r_round_count;

    state_t                w_next_state;
    logic [TICK_W-1:0]     w_next_timer;
    logic [2:0]            w_next_last;
    logic [NUM_HOLES-1:0]  w_next_led;
    logic                  w_next_hit;
    logic                  w_next_to;
    logic [7:0]            w_next_rc;
    logic [15:0]           w_lfsr;
    logic [2:0]            w_pick_idx;
    logic [TICK_W-1:0]     w_on_ticks;
    logic                  w_timer_last;

    mole_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_lfsr (w_lfsr)
    );

    assign w_pick_idx   = fold_idx(w_lfsr[2:0], r_last_idx);
    assign w_timer_last = (r_timer == TICK_W'(1));

    always_comb begin
        case (i_level)
            LVL_EASY: w_on_ticks = ON_TICKS_EASY;
            LVL_MED:  w_on_ticks = ON_TICKS_MED;
            default:  w_on_ticks = ON_TICKS_HARD;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_next_last  = r_last_idx;
        w_next_led   = r_mole_led;
        w_next_hit   = 1'b0;
        w_next_to    = 1'b0;
        w_next_rc    = r_round_count;

        case (r_state)
            IDLE: begin
                w_next_led = '0;
                if (i_enable) begin
                    w_next_state = PICK;
                    w_next_rc    = 8'd0;
                end
            end
            PICK: begin
                if (!i_enable) begin
                    w_next_state = IDLE;
                    w_next_led   = '0;
                end else begin
                    w_next_state = SHOW;
                    w_next_last  = w_pick_idx;
                    w_next_timer = w_on_ticks;
                    w_next_led   = NUM_HOLES'(1) << w_pick_idx;
                    w_next_rc    = (r_round_count == 8'hFF) ? r_round_count
                                                            : r_round_count + 8'd1;
                end
            end
            SHOW: begin
                // Disable outranks a hit, and a hit outranks expiry.
                if (!i_enable) begin
                    w_next_state = IDLE;
                    w_next_led   = '0;
                end else if (i_hit_vec[r_last_idx]) begin
                    w_next_state = GAP;
                    w_next_led   = '0;
                    w_next_hit   = 1'b1;
                    w_next_timer = GAP_TICKS;
                end else if (w_timer_last) begin
                    w_next_state = GAP;
                    w_next_led   = '0;
                    w_next_to    = 1'b1;
                    w_next_timer = GAP_TICKS;
                end else begin
                    w_next_timer = r_timer - TICK_W'(1);
                end
            end
            GAP: begin
                w_next_led = '0;
                if (!i_enable) begin
                    w_next_state = IDLE;
                end else if (w_timer_last) begin
                    w_next_state = PICK;
                end else begin
                    w_next_timer = r_timer - TICK_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_led   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_timer         <= '0;
            r_last_idx      <= 3'd0;
            r_mole_led      <= '0;
            r_hit_pulse     <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_round_count   <= 8'd0;
        end else begin
            r_state         <= w_next_state;
            r_timer         <= w_next_timer;
            r_last_idx      <= w_next_last;
            r_mole_led      <= w_next_led;
            r_hit_pulse     <= w_next_hit;
            r_timeout_pulse <= w_next_to;
            r_round_count   <= w_next_rc;
        end
    end

    assign o_mole_led      = r_mole_led;
    assign o_hit_pulse     = r_hit_pulse;
    assign o_timeout_pulse = r_timeout_pulse;
    assign o_round_count   = r_round_count;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler with short lifetimes (10/6/3, gap 4).
module tb_mole_scheduler;

    localparam int          ON_E  = 10;
    localparam int          ON_M  = 6;
    localparam int          ON_H  = 3;
    localparam int          GAPT  = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          EV_HIT = 1;
    localparam int          EV_TO  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic [1:0] i_level = 2'd0;
    logic [4:0] i_hit_vec = 5'd0;
    logic [4:0] o_mole_led;
    logic       o_hit_pulse;
    logic       o_timeout_pulse;
    logic [7:0] o_round_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;
    int          b_last = 0;
    int          b_rc   = 0;

    mole_scheduler #(
        .TICK_W        (32),
        .ON_TICKS_EASY (32'(ON_E)),
        .ON_TICKS_MED  (32'(ON_M)),
        .ON_TICKS_HARD (32'(ON_H)),
        .GAP_TICKS     (32'(GAPT)),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_enable        (i_enable),
        .i_level         (i_level),
        .i_hit_vec       (i_hit_vec),
        .o_mole_led      (o_mole_led),
        .o_hit_pulse     (o_hit_pulse),
        .o_timeout_pulse (o_timeout_pulse),
        .o_round_count   (o_round_count)
    );

    always #5 clk = ~clk;

    // Reference random source, kept in lock-step with the design's.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr      <= SEED;
            m_lfsr_prev <= SEED;
        end else begin
            m_lfsr      <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_lfsr_prev <= m_lfsr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called on the first lit sample: the PICK cycle's LFSR is m_lfsr_prev.
    task automatic predict_idx(output int e);
        int r;
        r = int'(m_lfsr_prev[2:0]);
        if (r >= 5) r = r - 3;
        if (r == b_last) r = (r == 4) ? 0 : r + 1;
        b_last = r;
        if (b_rc < 255) b_rc = b_rc + 1;
        e = r;
    endtask

    task automatic count_lit(input logic [4:0] led, output int n);
        n = 0;
        while (o_mole_led === led && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic count_dark(output int n, output int np);
        n  = 0;
        np = 0;
        while (o_mole_led === 5'd0 && n < 100) begin
            n++;
            np += int'(o_hit_pulse) + int'(o_timeout_pulse);
            step();
        end
    endtask

    function automatic int obs_kind();
        return (o_hit_pulse ? EV_HIT : 0) | (o_timeout_pulse ? EV_TO : 0);
    endfunction

    function automatic int pop_exp();
        if (exp_q.size() == 0) return 0;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        int bad;
        int e;
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({o_mole_led, o_hit_pulse, o_timeout_pulse, o_round_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: got led=%b hp=%b tp=%b rc=%0d, expected all 0",
                     o_mole_led, o_hit_pulse, o_timeout_pulse, o_round_count);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            step();
            if ({o_mole_led, o_hit_pulse, o_timeout_pulse, o_round_count} !== 15'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d non-zero cycles, expected 0", bad);
        end
        i_enable = 1'b1;
        b_rc = 0;
        step();
        n_checks++;
        if (o_mole_led !== 5'd0) begin
            n_fail++;
            $display("FAIL pick_dark: got led=%b, expected 00000", o_mole_led);
        end
        step();
        predict_idx(e);
        n_checks++;
        if (o_mole_led !== 5'(1 << e)) begin
            n_fail++;
            $display("FAIL first_mole: got led=%b, expected %b", o_mole_led, 5'(1 << e));
        end
        n_checks++;
        if (o_round_count !== 8'd1) begin
            n_fail++;
            $display("FAIL first_round_count: got %0d, expected 1", o_round_count);
        end
    endtask

    task automatic test_timeout_rounds();
        logic [4:0] cur;
        int n, d, np, e, ob, ex;
        i_level = 2'd0;
        for (int r = 0; r < 20; r++) begin
            cur = o_mole_led;
            exp_q.push_back(EV_TO);
            count_lit(cur, n);
            n_checks++;
            if (n != ON_E) begin
                n_fail++;
                $display("FAIL life_easy round %0d: got %0d cycles, expected %0d", r, n, ON_E);
            end
            ob = obs_kind();
            ex = pop_exp();
            n_checks++;
            if (ob != ex || o_mole_led !== 5'd0) begin
                n_fail++;
                $display("FAIL timeout_kind round %0d: got pulse=%0d led=%b, expected pulse=%0d led=00000",
                         r, ob, o_mole_led, ex);
            end
            count_dark(d, np);
            n_checks++;
            if (d != GAPT + 1 || np != 1) begin
                n_fail++;
                $display("FAIL gap_len round %0d: got dark=%0d pulses=%0d, expected dark=%0d pulses=1",
                         r, d, np, GAPT + 1);
            end
            predict_idx(e);
            n_checks++;
            if (o_mole_led !== 5'(1 << e) || o_mole_led === cur) begin
                n_fail++;
                $display("FAIL next_idx round %0d: got led=%b prev=%b, expected %b",
                         r, o_mole_led, cur, 5'(1 << e));
            end
        end
    endtask

    task automatic test_hit_med();
        logic [4:0] cur;
        int n, d, np, e, ob, ex;
        i_level = 2'd1;
        cur = o_mole_led;
        exp_q.push_back(EV_TO);
        count_lit(cur, n);
        n_checks++;
        if (n != ON_E) begin
            n_fail++;
            $display("FAIL level_held_in_show: got %0d cycles, expected %0d", n, ON_E);
        end
        ob = obs_kind();
        ex = pop_exp();
        n_checks++;
        if (ob != ex) begin
            n_fail++;
            $display("FAIL med_pre_timeout: got pulse=%0d, expected %0d", ob, ex);
        end
        count_dark(d, np);
        predict_idx(e);
        n_checks++;
        if (o_mole_led !== 5'(1 << e)) begin
            n_fail++;
            $display("FAIL med_idx: got led=%b, expected %b", o_mole_led, 5'(1 << e));
        end
        cur = o_mole_led;
        step();
        step();
        i_hit_vec = cur;
        exp_q.push_back(EV_HIT);
        step();
        i_hit_vec = 5'd0;
        ob = obs_kind();
        ex = pop_exp();
        n_checks++;
        if (ob != ex || o_mole_led !== 5'd0) begin
            n_fail++;
            $display("FAIL med_hit: got pulse=%0d led=%b, expected pulse=%0d led=00000",
                     ob, o_mole_led, ex);
        end
        count_dark(d, np);
        n_checks++;
        if (d != GAPT + 1 || np != 1) begin
            n_fail++;
            $display("FAIL hit_gap: got dark=%0d pulses=%0d, expected dark=%0d pulses=1",
                     d, np, GAPT + 1);
        end
        predict_idx(e);
        n_checks++;
        if (o_mole_led !== 5'(1 << e)) begin
            n_fail++;
            $display("FAIL med_idx2: got led=%b, expected %b", o_mole_led, 5'(1 << e));
        end
        cur = o_mole_led;
        i_hit_vec = ~cur;
        exp_q.push_back(EV_TO);
        count_lit(cur, n);
        i_hit_vec = 5'd0;
        n_checks++;
        if (n != ON_M) begin
            n_fail++;
            $display("FAIL wrong_hole_life: got %0d cycles, expected %0d", n, ON_M);
        end
        ob = obs_kind();
        ex = pop_exp();
        n_checks++;
        if (ob != ex) begin
            n_fail++;
            $display("FAIL wrong_hole_timeout: got pulse=%0d, expected %0d", ob, ex);
        end
    endtask

    task automatic test_hard_last_cycle();
        logic [4:0] cur;
        int n, d, np, e, ob, ex;
        i_level = 2'd2;
        count_dark(d, np);
        predict_idx(e);
        n_checks++;
        if (o_mole_led !== 5'(1 << e)) begin
            n_fail++;
            $display("FAIL hard_idx: got led=%b, expected %b", o_mole_led, 5'(1 << e));
        end
        cur = o_mole_led;
        step();
        step();
        i_hit_vec = cur;
        exp_q.push_back(EV_HIT);
        step();
        i_hit_vec = 5'd0;
        ob = obs_kind();
        ex = pop_exp();
        n_checks++;
        if (ob != ex) begin
            n_fail++;
            $display("FAIL last_cycle_hit: got pulse=%0d, expected %0d", ob, ex);
        end
        count_dark(d, np);
        n_checks++;
        if (np != 1) begin
            n_fail++;
            $display("FAIL last_cycle_pulses: got %0d pulses, expected 1", np);
        end
        predict_idx(e);
        cur = o_mole_led;
        i_level = 2'd0;
        exp_q.push_back(EV_TO);
        count_lit(cur, n);
        n_checks++;
        if (n != ON_H) begin
            n_fail++;
            $display("FAIL level_change_current: got %0d cycles, expected %0d", n, ON_H);
        end
        ob = obs_kind();
        ex = pop_exp();
        n_checks++;
        if (ob != ex) begin
            n_fail++;
            $display("FAIL hard_timeout: got pulse=%0d, expected %0d", ob, ex);
        end
        count_dark(d, np);
        predict_idx(e);
        cur = o_mole_led;
        exp_q.push_back(EV_TO);
        count_lit(cur, n);
        n_checks++;
        if (n != ON_E) begin
            n_fail++;
            $display("FAIL level_change_next: got %0d cycles, expected %0d", n, ON_E);
        end
        ob = obs_kind();
        ex = pop_exp();
        n_checks++;
        if (ob != ex) begin
            n_fail++;
            $display("FAIL easy_timeout: got pulse=%0d, expected %0d", ob, ex);
        end
    endtask

    task automatic test_enable_drop_reset();
        logic [4:0] cur;
        int d, np, e, bad, ob, ex;
        count_dark(d, np);
        predict_idx(e);
        cur = o_mole_led;
        step();
        step();
        i_enable = 1'b0;
        i_hit_vec = cur;
        step();
        i_hit_vec = 5'd0;
        n_checks++;
        if ({o_mole_led, o_hit_pulse, o_timeout_pulse} !== 7'd0) begin
            n_fail++;
            $display("FAIL drop_outputs: got led=%b hp=%b tp=%b, expected all 0",
                     o_mole_led, o_hit_pulse, o_timeout_pulse);
        end
        bad = 0;
        repeat (5) begin
            step();
            if ({o_mole_led, o_hit_pulse, o_timeout_pulse} !== 7'd0) bad++;
        end
        n_checks++;
        if (bad != 0 || o_round_count !== 8'(b_rc)) begin
            n_fail++;
            $display("FAIL idle_after_drop: got %0d active cycles rc=%0d, expected 0 and rc=%0d",
                     bad, o_round_count, b_rc);
        end
        i_enable = 1'b1;
        b_rc = 0;
        step();
        n_checks++;
        if (o_round_count !== 8'd0) begin
            n_fail++;
            $display("FAIL rc_clear: got %0d, expected 0", o_round_count);
        end
        step();
        predict_idx(e);
        n_checks++;
        if (o_mole_led !== 5'(1 << e) || o_round_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reenable_mole: got led=%b rc=%0d, expected led=%b rc=1",
                     o_mole_led, o_round_count, 5'(1 << e));
        end
        cur = o_mole_led;
        i_hit_vec = cur;
        exp_q.push_back(EV_HIT);
        step();
        i_hit_vec = 5'd0;
        ob = obs_kind();
        ex = pop_exp();
        n_checks++;
        if (ob != ex) begin
            n_fail++;
            $display("FAIL first_cycle_hit: got pulse=%0d, expected %0d", ob, ex);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_mole_led, o_hit_pulse, o_timeout_pulse, o_round_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset: got led=%b hp=%b tp=%b rc=%0d, expected all 0",
                     o_mole_led, o_hit_pulse, o_timeout_pulse, o_round_count);
        end
        b_last = 0;
        i_enable = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        logic [4:0] prev;
        int n, cyc, bad, e;
        i_level = 2'd2;
        i_enable = 1'b1;
        b_rc = 0;
        prev = 5'd0;
        n = 0;
        cyc = 0;
        bad = 0;
        while (n < 300 && cyc < 5000) begin
            step();
            cyc++;
            if (o_mole_led !== 5'd0 && prev === 5'd0) begin
                n++;
                predict_idx(e);
                if (o_mole_led !== 5'(1 << e) || o_round_count !== 8'(b_rc)) bad++;
            end
            prev = o_mole_led;
        end
        n_checks++;
        if (n != 300 || bad != 0) begin
            n_fail++;
            $display("FAIL sat_rounds: got %0d rounds with %0d bad, expected 300 with 0 bad", n, bad);
        end
        n_checks++;
        if (o_round_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_value: got %0d, expected 255", o_round_count);
        end
        i_enable = 1'b0;
        step();
        step();
        i_enable = 1'b1;
        b_rc = 0;
        step();
        n_checks++;
        if (o_round_count !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_clear: got %0d, expected 0", o_round_count);
        end
        step();
        predict_idx(e);
        n_checks++;
        if (o_round_count !== 8'd1 || o_mole_led !== 5'(1 << e)) begin
            n_fail++;
            $display("FAIL sat_restart: got rc=%0d led=%b, expected rc=1 led=%b",
                     o_round_count, o_mole_led, 5'(1 << e));
        end
    endtask

    initial begin
        test_reset();
        test_timeout_rounds();
        test_hit_med();
        test_hard_last_cycle();
        test_enable_drop_reset();
        test_saturation();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending events, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
